// File: rtl/mem_req_master.sv
// Requester side of the memory valid/ready interface: buffers local commands in a
// FIFO, issues one memory transaction at a time and reports each completion or timeout.
module mem_req_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int CMD_DEPTH  = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr_rd,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  wr_rd,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  valid,
    input  logic                  ready,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  rsp_valid,
    output logic                  rsp_wr_rd,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_timeout,
    output logic                  busy
);

    localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CNT_W = $clog2(CMD_DEPTH + 1);
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(CMD_DEPTH);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic {S_IDLE, S_REQ} state_e;

    typedef struct packed {
        logic                  wr_rd;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } cmd_t;

    cmd_t fifo_q [CMD_DEPTH];
    cmd_t cmd_in;
    cmd_t head;

    state_e                state_q, state_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic                  valid_q, valid_d;
    logic                  wr_rd_q, wr_rd_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_wr_rd_q, rsp_wr_rd_d;
    logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic                  push, pop;

    assign cmd_in = '{wr_rd: cmd_wr_rd, addr: cmd_addr, wdata: cmd_wdata};
    assign head   = fifo_q[rd_ptr_q];

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        tmo_d         = tmo_q;
        valid_d       = valid_q;
        wr_rd_d       = wr_rd_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rsp_valid_d   = 1'b0;
        rsp_wr_rd_d   = rsp_wr_rd_q;
        rsp_addr_d    = rsp_addr_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_timeout_d = rsp_timeout_q;
        push          = cmd_valid && (count_q != FULL);
        pop           = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (ready) begin
                    rsp_valid_d   = 1'b1;
                    rsp_wr_rd_d   = wr_rd_q;
                    rsp_addr_d    = addr_q;
                    rsp_rdata_d   = wr_rd_q ? '0 : rdata;
                    rsp_timeout_d = 1'b0;
                    if (count_q != '0) begin
                        pop = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                        state_d = S_IDLE;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    // Abort always returns to IDLE, so the next command sees a bubble
                    valid_d       = 1'b0;
                    state_d       = S_IDLE;
                    rsp_valid_d   = 1'b1;
                    rsp_wr_rd_d   = wr_rd_q;
                    rsp_addr_d    = addr_q;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pop) begin
            wr_rd_d  = head.wr_rd;
            addr_d   = head.addr;
            wdata_d  = head.wdata;
            valid_d  = 1'b1;
            tmo_d    = '0;
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            tmo_q         <= '0;
            valid_q       <= 1'b0;
            wr_rd_q       <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_wr_rd_q   <= 1'b0;
            rsp_addr_q    <= '0;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            tmo_q         <= tmo_d;
            valid_q       <= valid_d;
            wr_rd_q       <= wr_rd_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_wr_rd_q   <= rsp_wr_rd_d;
            rsp_addr_q    <= rsp_addr_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // Storage needs no reset: entries are only read once counted in
    always_ff @(posedge clk) begin
        if (res && push) begin
            fifo_q[wr_ptr_q] <= cmd_in;
        end
    end

    assign cmd_ready   = (count_q != FULL);
    assign busy        = (count_q != '0) || (state_q == S_REQ);
    assign valid       = valid_q;
    assign wr_rd       = wr_rd_q;
    assign addr        = addr_q;
    assign wdata       = wdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_wr_rd   = rsp_wr_rd_q;
    assign rsp_addr    = rsp_addr_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_mem_req_master.sv
// Bench for mem_req_master: transaction-level reference model feeding an expected
// response queue, a separate response monitor, and a randomised memory responder.
module tb_mem_req_master;

    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic          clk;
    logic          res;
    logic          cmd_valid, cmd_ready, cmd_wr_rd;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          wr_rd, valid, ready;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, rdata;
    logic          rsp_valid, rsp_wr_rd, rsp_timeout, busy;
    logic [AW-1:0] rsp_addr;
    logic [DW-1:0] rsp_rdata;

    mem_req_master #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .CMD_DEPTH (DEPTH),
        .TIMEOUT   (TMO)
    ) dut (
        .clk        (clk),
        .res        (res),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_wr_rd  (cmd_wr_rd),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .wr_rd      (wr_rd),
        .addr       (addr),
        .wdata      (wdata),
        .valid      (valid),
        .ready      (ready),
        .rdata      (rdata),
        .rsp_valid  (rsp_valid),
        .rsp_wr_rd  (rsp_wr_rd),
        .rsp_addr   (rsp_addr),
        .rsp_rdata  (rsp_rdata),
        .rsp_timeout(rsp_timeout),
        .busy       (busy)
    );

    typedef struct {
        bit          wr;
        bit [AW-1:0] addr;
        bit [DW-1:0] data;
        int unsigned pcyc;
    } cmd_t;

    typedef struct {
        bit          wr;
        bit [AW-1:0] addr;
        bit [DW-1:0] rdata;
        bit          tmo;
        int unsigned due;
    } rsp_t;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc    = 0;
    int unsigned tmo_seen = 0;

    cmd_t cmd_q[$];
    rsp_t exp_q[$];

    // Control from the stimulus to the responder
    bit          rnd_mode  = 0;
    int unsigned dir_wait  = 0;
    bit          use_fix   = 0;
    bit [DW-1:0] fix_rdata = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    // ---------------- reference model: what the bus and responses must look like
    cmd_t        cur;
    bit          in_txn    = 0;
    int unsigned held      = 0;
    bit          exp_valid = 0;
    int unsigned pending;

    always @(negedge clk) begin
        chk("valid", valid, exp_valid);
        if (valid && !in_txn) begin
            if (cmd_q.size() == 0) begin
                fail_now("issue", "valid with no accepted command outstanding");
            end else begin
                cur    = cmd_q.pop_front();
                in_txn = 1;
                held   = 0;
                checks++;
                if (cyc < cur.pcyc + 2) begin
                    errors++;
                    $display("FAIL latency: issued at %0d expected no earlier than %0d", cyc, cur.pcyc + 2);
                end
            end
        end
        if (in_txn)
            chk("req_fields", {wr_rd, addr, (cur.wr ? wdata : 32'h0)},
                {cur.wr, cur.addr, (cur.wr ? cur.data : 32'h0)});
        chk("cmd_ready", cmd_ready, cmd_q.size() != DEPTH);
        chk("busy", busy, (cmd_q.size() != 0) || in_txn);
        pending = cmd_q.size();
        if (!res) begin
            cmd_q.delete();
            while (exp_q.size() > 0 && exp_q[exp_q.size()-1].due > cyc) void'(exp_q.pop_back());
            in_txn    = 0;
            exp_valid = 0;
        end else begin
            if (cmd_valid && cmd_ready)
                cmd_q.push_back('{cmd_wr_rd, cmd_addr, cmd_wdata, cyc});
            if (in_txn) begin
                held++;
                if (ready) begin
                    exp_q.push_back('{cur.wr, cur.addr, (cur.wr ? '0 : rdata), 1'b0, cyc + 1});
                    in_txn    = 0;
                    exp_valid = (pending != 0);
                end else if (held == TMO) begin
                    exp_q.push_back('{cur.wr, cur.addr, '0, 1'b1, cyc + 1});
                    in_txn    = 0;
                    exp_valid = 0;
                end else begin
                    exp_valid = 1;
                end
            end else begin
                exp_valid = (pending != 0);
            end
        end
    end

    // ---------------- response monitor
    rsp_t        got;
    bit          last_wr = 0;
    bit [AW-1:0] last_addr = '0;
    bit [DW-1:0] last_rdata = '0;
    bit          last_tmo = 0;

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            got = exp_q.pop_front();
            fail_now("rsp_missing", $sformatf("no response for addr %0h due %0d", got.addr, got.due));
        end
        if (rsp_valid) begin
            if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
                fail_now("rsp_unexpected", $sformatf("rsp_valid with addr %0h", rsp_addr));
            end else begin
                got = exp_q.pop_front();
                chk("rsp_fields", {rsp_wr_rd, rsp_addr, rsp_rdata, rsp_timeout},
                    {got.wr, got.addr, got.rdata, got.tmo});
                if (rsp_timeout) tmo_seen++;
            end
            last_wr = rsp_wr_rd; last_addr = rsp_addr; last_rdata = rsp_rdata; last_tmo = rsp_timeout;
        end else begin
            chk("rsp_hold", {rsp_wr_rd, rsp_addr, rsp_rdata, rsp_timeout},
                {last_wr, last_addr, last_rdata, last_tmo});
        end
        if (!res) begin
            last_wr = 0; last_addr = '0; last_rdata = '0; last_tmo = 0;
        end
    end

    // ---------------- memory responder: ready after a per-transaction wait
    int unsigned hold = 0;
    int unsigned wait_n = 0;
    bit          last_v = 0, last_r = 0;

    function automatic int unsigned pick_wait();
        int unsigned s;
        s = $urandom_range(0, 9);
        if (s < 7) return $urandom_range(0, 3);
        case ($urandom_range(0, 3))
            0: return TMO - 2;
            1: return TMO - 1;
            2: return TMO;
            default: return 40;
        endcase
    endfunction

    initial begin
        ready = 1'b0;
        rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!res || (last_v && (last_r || hold == TMO))) hold = 0;
            if (valid) begin
                if (rnd_mode) begin
                    if (hold == 0) wait_n = pick_wait();
                end else begin
                    wait_n = dir_wait;
                end
                hold++;
                ready = (hold > wait_n);
            end else begin
                ready = 1'($urandom_range(0, 1));
            end
            last_v = valid;
            last_r = ready;
            rdata  = use_fix ? fix_rdata : DW'($urandom);
        end
    end

    // ---------------- stimulus
    task automatic align();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input bit wr, input bit [AW-1:0] a, input bit [DW-1:0] d);
        int unsigned n;
        cmd_valid = 1'b1;
        cmd_wr_rd = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        n = 0;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            n++;
            if (n > 200) begin
                fail_now("push_wait", "cmd_ready never asserted");
                break;
            end
            align();
        end
        align();
        cmd_valid = 1'b0;
        cmd_wdata = DW'($urandom);
    endtask

    task automatic wait_idle(input int unsigned limit);
        int unsigned n;
        n = 0;
        forever begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (n > limit) begin
                fail_now("idle_wait", "busy never dropped");
                break;
            end
        end
        repeat (2) @(negedge clk);
        align();
    endtask

    int unsigned t0;

    initial begin
        res = 1'b0;
        cmd_valid = 1'b0;
        cmd_wr_rd = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        repeat (2) @(posedge clk);
        #2 res = 1'b1;

        @(negedge clk);
        chk("reset_bus", {valid, wr_rd, addr, wdata}, '0);
        chk("reset_rsp", {rsp_valid, rsp_wr_rd, rsp_addr, rsp_rdata, rsp_timeout}, '0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_cmd_ready", cmd_ready, 1'b1);
        align();

        // Single write, ready immediate
        dir_wait = 0;
        push(1'b1, 8'h12, 32'hDEADBEEF);
        wait_idle(100);
        chk("write_rsp", {rsp_wr_rd, rsp_addr, rsp_rdata, rsp_timeout}, {1'b1, 8'h12, 32'h0, 1'b0});

        // Read with three wait states
        dir_wait  = 3;
        use_fix   = 1;
        fix_rdata = 32'hCAFE0001;
        push(1'b0, 8'h34, 32'h0);
        wait_idle(100);
        chk("read_rsp", {rsp_wr_rd, rsp_addr, rsp_rdata, rsp_timeout}, {1'b0, 8'h34, 32'hCAFE0001, 1'b0});
        use_fix = 0;

        // Fill the FIFO behind a stalled transaction, then release back-to-back
        dir_wait = 1000;
        for (int i = 0; i < 5; i++) push(i[0], 8'h40 + 8'(i), 32'h1000 + 32'(i));
        @(negedge clk);
        chk("full_cmd_ready", cmd_ready, 1'b0);
        dir_wait = 0;
        align();
        wait_idle(100);

        // Two stuck reads: each times out, second after a bubble
        t0 = tmo_seen;
        dir_wait = 1000;
        push(1'b0, 8'h56, 32'h0);
        push(1'b0, 8'h57, 32'h0);
        wait_idle(200);
        chk("timeout_count", tmo_seen - t0, 2);
        chk("timeout_rsp", {rsp_addr, rsp_rdata, rsp_timeout}, {8'h57, 32'h0, 1'b1});

        // Ready on the last allowed cycle completes; one later times out
        dir_wait = TMO - 1;
        push(1'b0, 8'h60, 32'h0);
        wait_idle(100);
        chk("boundary_ok", {rsp_addr, rsp_timeout}, {8'h60, 1'b0});
        dir_wait = TMO;
        push(1'b1, 8'h61, 32'h55);
        wait_idle(100);
        chk("boundary_tmo", {rsp_addr, rsp_timeout}, {8'h61, 1'b1});

        // Reset while a transaction is in flight with commands queued
        dir_wait = 1000;
        for (int i = 0; i < 4; i++) push(1'b1, 8'h70 + 8'(i), 32'h7000 + 32'(i));
        res = 1'b0;
        align();
        res = 1'b1;
        @(negedge clk);
        chk("rst_mid_state", {valid, busy, cmd_ready, rsp_valid}, {1'b0, 1'b0, 1'b1, 1'b0});
        align();
        repeat (20) align();

        // Randomised traffic
        rnd_mode = 1;
        for (int i = 0; i < 300; i++) begin
            push(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
            repeat ($urandom_range(0, 3)) align();
        end
        wait_idle(6000);
        rnd_mode = 0;

        chk("rsp_drain", exp_q.size(), 0);
        chk("cmd_drain", cmd_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

endmodule
